lut_table_loader: RTL and testbench
===================================

// Module: lut_table_loader
// PURPOSE
//  Upstream feeder for the serial-load LUT. Accepts table contents as parallel words over a
//  valid/ready handshake and serialises them MSB-first onto a bit/chip-select pair (sd_out, cs_n_out).
//  The LUT shift register samples one bit per clk edge while cs_n_out is low.
//  Streams exactly TABLE_BITS bits per load, then pulses done. The first bit sent lands in the table MSB.
// PARAMETERS
//  WORD_WIDTH   8    width of each parallel input word
//  TABLE_BITS   24   bits per load (2**IN_WIDTH*OUT_WIDTH of the target LUT; 24 = 3-in/3-out)
//  CNT_W        $clog2(TABLE_BITS+1)  width of bits_sent
// PORTS
//  clk        in   1           clock, rising edge; same clock as the LUT shift register
//  rst_n      in   1           reset, asynchronous, active-low
//  start      in   1           begin a load; sampled only in IDLE
//  abort      in   1           cancel the load in progress; takes priority over all else
//  word_in    in   WORD_WIDTH  next table word, MSB sent first
//  word_valid in   1           word_in valid
//  word_ready out  1           loader can accept word_in this cycle
//  sd_out     out  1           serial data to the LUT d input
//  cs_n_out   out  1           active-low shift enable to the LUT cs_n input
//  busy       out  1           high in WAIT_WORD or SHIFT
//  done       out  1           one-cycle pulse after the final bit
//  bits_sent  out  CNT_W       bits emitted in the current or last load
// BEHAVIOUR
//  Reset values: word_ready=0, sd_out=0, cs_n_out=1, busy=0, done=0, bits_sent=0, state=IDLE.
//  All outputs are registered. word_ready is decoded from the state register.
//  States:
//   IDLE: cs_n_out=1.
//    - If start is high, go to WAIT_WORD and clear bits_sent.
//    - done=1 only in the first IDLE cycle after a completed load. start is accepted in that cycle.
//   WAIT_WORD: word_ready=1, cs_n_out=1.
//    - A transfer happens on an edge where word_valid&&word_ready are both high.
//    - On transfer: load buf=word_in, bit_idx=WORD_WIDTH-1, go to SHIFT.
//   SHIFT: cs_n_out=0, sd_out=buf[bit_idx], word_ready=0.
//    - Each edge: bits_sent+=1, bit_idx-=1.
//    - If bits_sent reaches TABLE_BITS: go to IDLE, cs_n_out=1, done=1.
//    - Else if bit_idx was 0: go to WAIT_WORD.
//    - Else: stay in SHIFT.
//  Timing:
//   - Word accepted at edge m: bit b[W-1] is driven after edge m, b[0] after edge m+W-1.
//   - Zero added latency. A word accepted in the cycle after its predecessor's last bit gives one cs_n_out=1 gap.
//   - Gaps (cs_n_out=1) are legal: the LUT holds its contents, so no bits are lost or duplicated.
//  Non-multiple TABLE_BITS: the final word contributes only its top (TABLE_BITS mod WORD_WIDTH) bits.
//   Its remaining bits are discarded and no further word is requested.
//  start while busy: ignored. start and abort together in IDLE: abort wins, stay in IDLE.
//  abort in any state: next edge -> IDLE, cs_n_out=1, word_ready=0, done=0.
//   - bits_sent holds its value. The partial table is left in the LUT.
//  rst_n low mid-load: immediate return to reset values. cs_n_out goes high asynchronously, so the LUT stops shifting.
//  sd_out is don't-care whenever cs_n_out=1. It holds its last value in that case.
//  bits_sent saturates at TABLE_BITS and never wraps.
// TESTING
//  1. Full load, defaults: words 0xFA,0xC6,0x88, word_valid always high.
//     -> 24 cs_n_out-low cycles in three groups of 8, separated by one-cycle gaps.
//     -> Model shift reg = 0xFAC688. done pulses once. bits_sent=24.
//  2. Backpressure: hold word_valid low 5 cycles before the second word.
//     -> cs_n_out=1 and word_ready=1 throughout the gap. Final table still 0xFAC688.
//  3. Abort after 11 bits: abort=1 for one cycle.
//     -> cs_n_out=1 next cycle, done never asserts, bits_sent=11.
//     -> A following start+full load yields the correct 24-bit table.
//  4. Async reset mid-word, with rst_n low between clk edges.
//     -> cs_n_out=1 and busy=0 immediately, without waiting for an edge.
//     -> After release, start reloads correctly.
//  5. start re-asserted during SHIFT -> no restart and no extra word_ready. Exactly 24 bits emitted.
//  6. TABLE_BITS=20: words 0xAB,0xCD,0xEF.
//     -> 20 bits sent (0xABCDE). Low nibble of 0xEF never sent. done after the 20th bit.

Source files
------------

// File: rtl/lut_table_loader.sv
// lut_table_loader: feeds a serial-load LUT. Parallel words arrive over a
// valid/ready handshake and are shifted out MSB-first on sd_out while
// cs_n_out is low. Exactly TABLE_BITS bits go out per load, then done pulses.
//
// Handshake: a word moves from the producer into the loader on a rising clk
// edge where word_valid and word_ready are both high. word_ready depends only
// on the state register (never on word_valid). The producer may hold word_valid
// low for any number of cycles; the loader then idles with cs_n_out high and
// the LUT keeps its contents.
module lut_table_loader #(
    parameter int WORD_WIDTH = 8,
    parameter int TABLE_BITS = 24,
    parameter int CNT_W      = $clog2(TABLE_BITS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [WORD_WIDTH-1:0] word_in,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  sd_out,
    output logic                  cs_n_out,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      bits_sent,
    output logic [1:0]            state_dbg_o
);

    localparam int IDX_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_WORD = 2'd1,
        SHIFT     = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [WORD_WIDTH-1:0] buf_q, buf_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  sd_q, sd_d;
    logic                  cs_n_q, cs_n_d;
    logic                  done_q, done_d;
    logic [CNT_W-1:0]      bits_q, bits_d;
    logic [CNT_W-1:0]      bits_inc;

    // Saturating increment: the count never passes TABLE_BITS.
    assign bits_inc = (bits_q == CNT_W'(TABLE_BITS)) ? bits_q : bits_q + 1'b1;

    // Register all state and outputs; reset drops cs_n_out high immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            buf_q   <= '0;
            idx_q   <= '0;
            sd_q    <= 1'b0;
            cs_n_q  <= 1'b1;
            done_q  <= 1'b0;
            bits_q  <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            idx_q   <= idx_d;
            sd_q    <= sd_d;
            cs_n_q  <= cs_n_d;
            done_q  <= done_d;
            bits_q  <= bits_d;
        end
    end

    // Next-state and next-output decode; abort overrides every state.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        idx_d   = idx_q;
        sd_d    = sd_q;
        cs_n_d  = 1'b1;
        done_d  = 1'b0;
        bits_d  = bits_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = WAIT_WORD;
                        bits_d  = '0;
                    end
                end
                WAIT_WORD: begin
                    if (word_valid) begin
                        state_d = SHIFT;
                        buf_d   = word_in;
                        idx_d   = IDX_W'(WORD_WIDTH - 1);
                        sd_d    = word_in[WORD_WIDTH-1];
                        cs_n_d  = 1'b0;
                    end
                end
                SHIFT: begin
                    // The bit on sd_out is captured by the LUT at this edge.
                    bits_d = bits_inc;
                    if (bits_inc == CNT_W'(TABLE_BITS)) begin
                        // Any unsent low bits of a final partial word are dropped.
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (idx_q == '0) begin
                        state_d = WAIT_WORD;
                    end else begin
                        idx_d  = idx_q - 1'b1;
                        sd_d   = buf_q[idx_d];
                        cs_n_d = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign word_ready  = (state_q == WAIT_WORD);
    assign busy        = (state_q == WAIT_WORD) || (state_q == SHIFT);
    assign sd_out      = sd_q;
    assign cs_n_out    = cs_n_q;
    assign done        = done_q;
    assign bits_sent   = bits_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_lut_table_loader.sv
// tb_lut_table_loader: drives table loads into a 24-bit and a 20-bit loader,
// models the LUT shift register and checks every serialised bit against the
// words that were handed over.
module tb_lut_table_loader;

    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          word_valid = 1'b0;
    logic [7:0]    word_in = 8'h00;
    logic          sel = 1'b0;

    logic          rdy_a, sd_a, csn_a, busy_a, done_a;
    logic [CW-1:0] bits_a;
    logic [1:0]    st_a;
    logic          rdy_b, sd_b, csn_b, busy_b, done_b;
    logic [CW-1:0] bits_b;
    logic [1:0]    st_b;

    logic          m_ready, m_sd, m_cs_n, m_busy, m_done;
    logic [CW-1:0] m_bits;
    logic [1:0]    m_state;

    always #5 clk = ~clk;

    lut_table_loader #(.WORD_WIDTH(8), .TABLE_BITS(24)) dut (
        .clk(clk), .rst_n(rst_n), .start(start & ~sel), .abort(abort & ~sel),
        .word_in(word_in), .word_valid(word_valid & ~sel), .word_ready(rdy_a),
        .sd_out(sd_a), .cs_n_out(csn_a), .busy(busy_a), .done(done_a),
        .bits_sent(bits_a), .state_dbg_o(st_a)
    );

    lut_table_loader #(.WORD_WIDTH(8), .TABLE_BITS(20)) dut20 (
        .clk(clk), .rst_n(rst_n), .start(start & sel), .abort(abort & sel),
        .word_in(word_in), .word_valid(word_valid & sel), .word_ready(rdy_b),
        .sd_out(sd_b), .cs_n_out(csn_b), .busy(busy_b), .done(done_b),
        .bits_sent(bits_b), .state_dbg_o(st_b)
    );

    assign m_ready = sel ? rdy_b  : rdy_a;
    assign m_sd    = sel ? sd_b   : sd_a;
    assign m_cs_n  = sel ? csn_b  : csn_a;
    assign m_busy  = sel ? busy_b : busy_a;
    assign m_done  = sel ? done_b : done_a;
    assign m_bits  = sel ? bits_b : bits_a;
    assign m_state = sel ? st_b   : st_a;

    typedef struct {
        logic        sel;
        logic [7:0]  w0, w1, w2;
        int          gap;
        bit          spam;
        logic [23:0] exp_table;
        int          exp_bits;
    } vec_t;

    vec_t        vecs[5];
    int          tests = 0;
    int          fails = 0;
    logic [0:0]  exp_q[$];
    int          rem;
    logic [23:0] lut_model;
    int          low_cnt, high_cnt, done_cnt, bad_ready;
    bit          mon_en = 1'b0;
    bit          spam = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        lut_model = '0;
        low_cnt   = 0;
        high_cnt  = 0;
        done_cnt  = 0;
        bad_ready = 0;
    endtask

    // LUT model and scoreboard: each cs_n-low cycle shifts one bit in.
    initial forever begin
        @(negedge clk);
        if (mon_en && rst_n) begin
            if (!m_cs_n) begin
                low_cnt++;
                lut_model = {lut_model[22:0], m_sd};
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_bit: got bit %0d expected none", m_sd);
                end else begin
                    check("serial_bit", {31'd0, m_sd}, {31'd0, exp_q.pop_front()});
                end
            end else if (m_busy) begin
                high_cnt++;
                if (!m_ready) bad_ready++;
            end
            if (m_done) done_cnt++;
        end
    end

    task automatic start_load(input logic s, input int tbits);
        sel = s;
        rem = tbits;
        @(negedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input int gap);
        int n;
        n = 0;
        if (gap > 0) begin
            word_valid = 1'b0;
            @(negedge clk);
            while (!m_ready && n < 100) begin
                @(negedge clk);
                n++;
            end
            repeat (gap) @(negedge clk);
            #1;
        end
        word_in    = w;
        word_valid = 1'b1;
        n = 0;
        while (!m_ready) begin
            start = spam;
            @(negedge clk);
            n++;
            if (n > 200) begin
                tests++;
                fails++;
                $display("FAIL word_accept_timeout: got no word_ready expected word_ready within 200 cycles");
                return;
            end
        end
        for (int i = 7; i >= 0; i--) begin
            if (rem > 0) begin
                exp_q.push_back(w[i]);
                rem--;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (m_done) begin
                start = 1'b0;
                break;
            end
            start = spam;
            n++;
            if (n > 200) begin
                tests++;
                fails++;
                $display("FAIL done_timeout: got no done expected done within 200 cycles");
                break;
            end
        end
    endtask

    task automatic wait_bits(input int target);
        int n;
        n = 0;
        while (int'(m_bits) != target && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("bits_reached", {27'd0, m_bits}, target);
    endtask

    task automatic run_vec(input vec_t v);
        clear_model();
        spam   = v.spam;
        mon_en = 1'b1;
        start_load(v.sel, v.exp_bits);
        send_word(v.w0, 0);
        send_word(v.w1, v.gap);
        send_word(v.w2, 0);
        word_valid = 1'b0;
        wait_done();
        spam  = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("table", {8'd0, lut_model}, {8'd0, v.exp_table});
        check("bits_sent", {27'd0, m_bits}, v.exp_bits);
        check("low_cycles", low_cnt, v.exp_bits);
        check("exp_q_empty", exp_q.size(), 0);
        check("done_pulses", done_cnt, 1);
        check("high_cycles", high_cnt, v.gap + 3);
        check("ready_in_gap", bad_ready, 0);
        check("idle_cs_n", {31'd0, m_cs_n}, 1);
        check("idle_busy", {31'd0, m_busy}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] r0, r1, r2;
        r0 = 8'($urandom_range(0, 255));
        r1 = 8'($urandom_range(0, 255));
        r2 = 8'($urandom_range(0, 255));
        vecs[0] = '{1'b0, 8'hFA, 8'hC6, 8'h88, 0, 1'b0, 24'hFAC688, 24};
        vecs[1] = '{1'b0, 8'hFA, 8'hC6, 8'h88, 5, 1'b0, 24'hFAC688, 24};
        vecs[2] = '{1'b0, 8'h00, 8'hFF, 8'h5A, 0, 1'b1, 24'h00FF5A, 24};
        vecs[3] = '{1'b1, 8'hAB, 8'hCD, 8'hEF, 0, 1'b0, 24'h0ABCDE, 20};
        vecs[4] = '{1'b0, r0, r1, r2, int'($urandom_range(1, 4)), 1'b0, {r0, r1, r2}, 24};

        // Reset values while held in reset, then after release.
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, m_ready}, 0);
        check("rst_sd", {31'd0, m_sd}, 0);
        check("rst_cs_n", {31'd0, m_cs_n}, 1);
        check("rst_busy", {31'd0, m_busy}, 0);
        check("rst_done", {31'd0, m_done}, 0);
        check("rst_bits", {27'd0, m_bits}, 0);
        check("rst_state", {30'd0, m_state}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_cs_n_after_rst", {31'd0, m_cs_n}, 1);

        // start and abort together in IDLE: stay idle.
        #1 start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", {31'd0, busy_a}, 0);
        check("start_abort_state", {30'd0, st_a}, 0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Abort after 11 bits.
        clear_model();
        mon_en = 1'b1;
        start_load(1'b0, 24);
        send_word(8'h3C, 0);
        send_word(8'hA5, 0);
        word_valid = 1'b0;
        wait_bits(11);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("abort_cs_n", {31'd0, m_cs_n}, 1);
        check("abort_busy", {31'd0, m_busy}, 0);
        check("abort_ready", {31'd0, m_ready}, 0);
        repeat (4) @(negedge clk);
        check("abort_bits", {27'd0, m_bits}, 11);
        check("abort_done", done_cnt, 0);
        check("abort_low_cycles", low_cnt, 12);
        run_vec(vecs[0]);

        // Asynchronous reset between clock edges, mid-word.
        clear_model();
        mon_en = 1'b1;
        start_load(1'b0, 24);
        send_word(8'h96, 0);
        word_valid = 1'b0;
        wait_bits(3);
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_cs_n", {31'd0, m_cs_n}, 1);
        check("arst_busy", {31'd0, m_busy}, 0);
        check("arst_ready", {31'd0, m_ready}, 0);
        check("arst_bits", {27'd0, m_bits}, 0);
        check("arst_sd", {31'd0, m_sd}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
